counter_seq_ctrl: RTL and testbench

Sequencer that drives the ADVANCE_COUNTER / RESET_COUNTER inputs of the counter control block on the ASIC tester board. It accepts one command at a time over a valid/ready handshake: reset, advance N, or reset-then-advance N. It generates pulses of guaranteed width and spacing for the external negative-edge counter ICs and tracks the expected counter position. It sits between the test-sequencing FSM and the counter control block.

---
 rtl/counter_seq_pkg.sv | 29 ++
 rtl/counter_seq_ctrl_seq_timer.sv | 33 +++
 rtl/counter_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared command encodings and state enum for the counter sequencer
package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_RESET   = 2'd1,
    OP_ADVANCE = 2'd2,
    OP_RST_ADV = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_PULSE,
    ST_RST_RECOV,
    ST_ADV_PULSE,
    ST_ADV_GAP,
    ST_FINISH
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_seq_timer.sv
// rtl/counter_seq_ctrl_seq_timer.sv - loadable down-counter with zero flag for phase durations
module seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - pulse sequencer for the tester-board counter ICs with position tracking
// Optional ABORT input enabled by defining COUNTER_SEQ_ABORT_EN.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int RST_CYCLES   = 3,
  parameter int RECOV_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_COUNT,
`ifdef COUNTER_SEQ_ABORT_EN
  input  logic             ABORT,
`endif
  output logic             ADVANCE_COUNTER,
  output logic             RESET_COUNTER,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] POSITION
);

  localparam int TMAX = max4(PULSE_CYCLES, GAP_CYCLES, RST_CYCLES, RECOV_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] RST_LD   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] RECOV_LD = TW'(RECOV_CYCLES - 1);

  state_e           state_q, state_d;
  cmd_op_e          op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             adv_q, rst_q, busy_q, done_q, ready_q;
  logic             abort_w;
  logic             t_load, t_zero;
  logic [TW-1:0]    t_load_val;

`ifdef COUNTER_SEQ_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && ready_q) begin
          op_d  = cmd_op_e'(CMD_OP);
          rem_d = CMD_COUNT;
          if (CMD_OP == OP_RESET || CMD_OP == OP_RST_ADV) begin
            state_d = ST_RST_PULSE;
            pos_d   = '0;
          end else if (CMD_OP == OP_ADVANCE && CMD_COUNT != '0) begin
            state_d = ST_ADV_PULSE;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_RST_PULSE: if (t_zero) state_d = ST_RST_RECOV;
      ST_RST_RECOV: begin
        if (t_zero) begin
          state_d = (op_q == OP_RST_ADV && rem_q != '0) ? ST_ADV_PULSE : ST_FINISH;
        end
      end
      ST_ADV_PULSE: begin
        if (t_zero) begin
          pos_d   = pos_q + CNT_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? ST_FINISH : ST_ADV_GAP;
        end
      end
      ST_ADV_GAP:   if (t_zero) state_d = ST_ADV_PULSE;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    // A cut-short pulse must not count: abort overrides the final-cycle increment.
    if (abort_w && state_q != ST_IDLE && state_q != ST_FINISH) begin
      state_d = ST_FINISH;
      pos_d   = pos_q;
      rem_d   = '0;
    end
  end

  always_comb begin
    t_load     = (state_d != state_q);
    t_load_val = '0;
    case (state_d)
      ST_RST_PULSE: t_load_val = RST_LD;
      ST_RST_RECOV: t_load_val = RECOV_LD;
      ST_ADV_PULSE: t_load_val = PULSE_LD;
      ST_ADV_GAP:   t_load_val = GAP_LD;
      default:      t_load_val = '0;
    endcase
  end

  seq_timer #(.W(TW)) u_timer (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load_i     (t_load),
    .load_val_i (t_load_val),
    .zero_o     (t_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      rem_q   <= '0;
      pos_q   <= '0;
      adv_q   <= 1'b0;
      rst_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      adv_q   <= (state_d == ST_ADV_PULSE);
      rst_q   <= (state_d == ST_RST_PULSE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FINISH);
      ready_q <= (state_d == ST_IDLE);
    end
  end

  assign CMD_READY       = ready_q;
  assign ADVANCE_COUNTER = adv_q;
  assign RESET_COUNTER   = rst_q;
  assign BUSY            = busy_q;
  assign DONE            = done_q;
  assign POSITION        = pos_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - scoreboard bench for counter_seq_ctrl against a per-cycle waveform model
module tb_counter_seq_ctrl;

  localparam int CNT_W = 8;
  localparam int PULSE = 2;
  localparam int GAP   = 2;
  localparam int RSTC  = 3;
  localparam int RECOV = 2;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             CMD_VALID = 1'b0;
  logic [1:0]       CMD_OP = 2'd0;
  logic [CNT_W-1:0] CMD_COUNT = '0;
  logic             CMD_READY, ADVANCE_COUNTER, RESET_COUNTER, BUSY, DONE;
  logic [CNT_W-1:0] POSITION;
`ifdef COUNTER_SEQ_ABORT_EN
  logic             ABORT = 1'b0;
`endif

  typedef struct packed {
    logic             adv;
    logic             rst;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] pos;
  } obs_t;

  obs_t             exp_q[$];
  obs_t             m_e, m_a;
  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] m_pos = '0;
  logic [CNT_W-1:0] last_pos = '0;
  bit               mon_en = 1'b0;

  counter_seq_ctrl #(
    .CNT_W(CNT_W), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP),
    .RST_CYCLES(RSTC), .RECOV_CYCLES(RECOV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_COUNT(CMD_COUNT),
`ifdef COUNTER_SEQ_ABORT_EN
    .ABORT(ABORT),
`endif
    .ADVANCE_COUNTER(ADVANCE_COUNTER), .RESET_COUNTER(RESET_COUNTER),
    .BUSY(BUSY), .DONE(DONE), .POSITION(POSITION)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic obs_t el(input bit adv, input bit rst, input bit done, input bit busy,
                              input logic [CNT_W-1:0] pos);
    el = '{adv, rst, done, busy, pos};
  endfunction

  // Expected outputs for every cycle from the one before acceptance to the DONE cycle.
  task automatic push_model(input logic [1:0] op, input int cnt);
    int n;
    exp_q.push_back(el(0, 0, 0, 0, m_pos));
    if (op == 2'd1 || op == 2'd3) begin
      m_pos = '0;
      repeat (RSTC) exp_q.push_back(el(0, 1, 0, 1, m_pos));
      repeat (RECOV) exp_q.push_back(el(0, 0, 0, 1, m_pos));
    end
    n = (op == 2'd2 || op == 2'd3) ? cnt : 0;
    for (int i = 0; i < n; i++) begin
      repeat (PULSE) exp_q.push_back(el(1, 0, 0, 1, m_pos));
      m_pos = m_pos + 1'b1;
      if (i < n - 1) repeat (GAP) exp_q.push_back(el(0, 0, 0, 1, m_pos));
    end
    exp_q.push_back(el(0, 0, 1, 1, m_pos));
  endtask

  always @(negedge CLK) begin
    if (mon_en && RST_N) begin
      if (exp_q.size() > 0) m_e = exp_q.pop_front();
      else m_e = el(0, 0, 0, 0, last_pos);
      last_pos = m_e.pos;
      m_a = '{ADVANCE_COUNTER, RESET_COUNTER, DONE, BUSY, POSITION};
      check("cycle{adv,rst,done,busy,pos}", 32'(m_a), 32'(m_e));
      check("no_overlap", {31'b0, ADVANCE_COUNTER & RESET_COUNTER}, 32'd0);
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input int cnt);
    int guard;
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_COUNT = CNT_W'(cnt);
    guard = 0;
    while (!CMD_READY && guard < 5000) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (!CMD_READY) begin
      check("ready_timeout", 32'd0, 32'd1);
      CMD_VALID = 1'b0;
      return;
    end
    push_model(op, cnt);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (exp_q.size() != 0) check("idle_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #1;
    check("rst_adv", {31'b0, ADVANCE_COUNTER}, 32'd0);
    check("rst_rst", {31'b0, RESET_COUNTER}, 32'd0);
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_done", {31'b0, DONE}, 32'd0);
    check("rst_ready", {31'b0, CMD_READY}, 32'd0);
    check("rst_pos", 32'(POSITION), 32'd0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("ready_after_reset", {31'b0, CMD_READY}, 32'd1);
    mon_en = 1'b1;

    issue(2'd1, 0);
    issue(2'd2, 4);
    issue(2'd2, 6);
    issue(2'd3, 3);
    issue(2'd2, 0);
    issue(2'd0, 5);
    wait_idle();
    check("pos_after_rst_adv", 32'(POSITION), 32'd3);

    issue(2'd2, 255 - int'(m_pos));
    wait_idle();
    check("pos_max", 32'(POSITION), 32'd255);
    issue(2'd2, 1);
    wait_idle();
    check("pos_wrap", 32'(POSITION), 32'd0);

    issue(2'd2, 2);
    issue(2'd1, 0);
    issue(2'd2, 1);
    repeat (20) issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
    wait_idle();

    issue(2'd2, 5);
    begin
      int guard;
      guard = 0;
      while (!ADVANCE_COUNTER && guard < 50) begin
        @(posedge CLK); #1;
        guard++;
      end
    end
    @(posedge CLK); #2;
    mon_en = 1'b0;
    RST_N  = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_adv", {31'b0, ADVANCE_COUNTER}, 32'd0);
    check("midrst_busy", {31'b0, BUSY}, 32'd0);
    check("midrst_done", {31'b0, DONE}, 32'd0);
    check("midrst_pos", 32'(POSITION), 32'd0);
    m_pos    = '0;
    last_pos = '0;
    @(posedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("midrst_ready", {31'b0, CMD_READY}, 32'd1);
    mon_en = 1'b1;
    issue(2'd2, 3);
    wait_idle();

`ifdef COUNTER_SEQ_ABORT_EN
    mon_en    = 1'b0;
    CMD_VALID = 1'b1;
    CMD_OP    = 2'd2;
    CMD_COUNT = CNT_W'(5);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    check("abort_in_pulse2", {31'b0, ADVANCE_COUNTER}, 32'd1);
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    check("abort_adv", {31'b0, ADVANCE_COUNTER}, 32'd0);
    check("abort_done", {31'b0, DONE}, 32'd1);
    check("abort_pos", 32'(POSITION), 32'(m_pos + 1'b1));
    @(posedge CLK); #1;
    check("abort_idle", {31'b0, BUSY}, 32'd0);
    m_pos    = m_pos + 1'b1;
    last_pos = m_pos;
    mon_en   = 1'b1;
    issue(2'd2, 2);
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
